// File: rtl/cam_mem_arbiter.sv
// Round-robin sequencer for the shared synchronous-read CAM memory port: grants one read
// burst at a time, issues its addresses and returns owner-tagged data RD_LAT cycles later.
module cam_mem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 4,
  parameter int RD_LAT  = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      mem_ce,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_q,
  output logic [NUM_REQ-1:0]        rd_vld,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_last,
  output logic                      busy
);

  localparam int PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  if (NUM_REQ < 2 || RD_LAT < 1) begin : g_bad_params
    $error("cam_mem_arbiter: NUM_REQ must be >= 2 and RD_LAT >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  state_t                     state;
  logic [PW-1:0]              ptr;
  logic [PW-1:0]              owner;
  logic [NUM_REQ-1:0]         owner_oh;
  logic [LEN_W-1:0]           len_q;
  logic [LEN_W-1:0]           wcnt;
  logic [DCW-1:0]             dcnt;
  logic                       mem_last;

  logic                       pick_any;
  logic [PW-1:0]              pick;
  logic [NUM_REQ-1:0]         pick_oh;
  logic [PW:0]                arb_idx;

  logic [RD_LAT-1:0][NUM_REQ-1:0] pipe_vld;
  logic [RD_LAT-1:0]              pipe_last;

  // Rotating priority search: first set request at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_any = 1'b0;
    pick     = '0;
    pick_oh  = '0;
    arb_idx  = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      arb_idx = {1'b0, ptr} + (PW+1)'(off);
      if (arb_idx >= (PW+1)'(NUM_REQ)) arb_idx = arb_idx - (PW+1)'(NUM_REQ);
      if (!pick_any && req[arb_idx[PW-1:0]]) begin
        pick_any                  = 1'b1;
        pick                      = arb_idx[PW-1:0];
        pick_oh[arb_idx[PW-1:0]]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      owner_oh <= '0;
      len_q    <= '0;
      wcnt     <= '0;
      dcnt     <= '0;
      mem_last <= 1'b0;
      gnt      <= '0;
      mem_ce   <= 1'b0;
      mem_addr <= '0;
      busy     <= 1'b0;
    end else begin
      gnt <= '0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            state    <= ISSUE;
            owner    <= pick;
            owner_oh <= pick_oh;
            len_q    <= req_len[pick*LEN_W +: LEN_W];
            wcnt     <= '0;
            mem_last <= (req_len[pick*LEN_W +: LEN_W] == '0);
            gnt      <= pick_oh;
            mem_ce   <= 1'b1;
            mem_addr <= req_addr[pick*ADDR_W +: ADDR_W];
            busy     <= 1'b1;
          end
        end
        ISSUE: begin
          if (wcnt == len_q) begin
            state    <= DRAIN;
            mem_ce   <= 1'b0;
            mem_last <= 1'b0;
            dcnt     <= DCW'(RD_LAT - 1);
          end else begin
            wcnt     <= wcnt + LEN_W'(1);
            mem_addr <= mem_addr + ADDR_W'(1);
            mem_last <= ((wcnt + LEN_W'(1)) == len_q);
          end
        end
        DRAIN: begin
          if (dcnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            ptr   <= (owner == PW'(NUM_REQ - 1)) ? '0 : owner + PW'(1);
          end else begin
            dcnt <= dcnt - DCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag pipeline: one stage per cycle of memory latency, aligned with mem_q.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
    end else begin
      pipe_vld[0]  <= mem_ce ? owner_oh : '0;
      pipe_last[0] <= mem_ce & mem_last;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  assign rd_vld  = pipe_vld[RD_LAT-1];
  assign rd_last = pipe_last[RD_LAT-1];
  assign rd_data = mem_q;

endmodule

// File: tb/tb_cam_mem_arbiter.sv
// Directed bench for cam_mem_arbiter: table of bursts with hand-derived owners, plus
// idle, reset-state and reset-mid-burst sequences. Memory model returns {C0DE5A, addr}.
module tb_cam_mem_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = 4;
  localparam int RD_LAT  = 2;

  logic                      clock;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ-1:0]        gnt;
  logic                      mem_ce;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_q;
  logic [NUM_REQ-1:0]        rd_vld;
  logic [DATA_W-1:0]         rd_data;
  logic                      rd_last;
  logic                      busy;

  int n_tests = 0;
  int n_fail  = 0;

  cam_mem_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .req_addr(req_addr),
    .req_len (req_len),
    .gnt     (gnt),
    .mem_ce  (mem_ce),
    .mem_addr(mem_addr),
    .mem_q   (mem_q),
    .rd_vld  (rd_vld),
    .rd_data (rd_data),
    .rd_last (rd_last),
    .busy    (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Two-cycle synchronous-read memory: data depends only on the address issued.
  logic [ADDR_W-1:0] ma1, ma2;
  always @(posedge clock) begin
    ma1 <= mem_addr;
    ma2 <= ma1;
  end
  assign mem_q = {24'hC0DE5A, ma2};

  typedef struct {
    logic [1:0] rq;
    logic [7:0] a0;
    logic [7:0] a1;
    logic [3:0] l0;
    logic [3:0] l1;
    int         owner;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " gnt"},    32'(gnt),     32'h0);
    chk({tag, " mem_ce"}, 32'(mem_ce),  32'h0);
    chk({tag, " rd_vld"}, 32'(rd_vld),  32'h0);
    chk({tag, " rd_last"},32'(rd_last), 32'h0);
    chk({tag, " busy"},   32'(busy),    32'h0);
  endtask

  // Called at a negedge (cycle t); checks cycles t+1 .. t+len+RD_LAT+2.
  task automatic run_burst(input vec_t v, input int idx);
    logic [7:0]         base;
    int                 len;
    logic [1:0]         oh;
    logic [7:0]         ea;
    logic [1:0]         e_vld;
    string              tg;
    req      = v.rq;
    req_addr = {v.a1, v.a0};
    req_len  = {v.l1, v.l0};
    base     = (v.owner == 0) ? v.a0 : v.a1;
    len      = (v.owner == 0) ? int'(v.l0) : int'(v.l1);
    oh       = 2'b01 << v.owner;
    for (int j = 1; j <= len + RD_LAT + 2; j++) begin
      @(negedge clock);
      tg = $sformatf("v%0d c%0d", idx, j);
      chk({tg, " gnt"},    32'(gnt),    32'((j == 1) ? oh : 2'b00));
      chk({tg, " mem_ce"}, 32'(mem_ce), 32'(j <= len + 1));
      if (j <= len + 1) begin
        ea = base + 8'(j - 1);
        chk({tg, " mem_addr"}, 32'(mem_addr), 32'(ea));
      end
      e_vld = (j >= RD_LAT + 1 && j <= len + 1 + RD_LAT) ? oh : 2'b00;
      chk({tg, " rd_vld"},  32'(rd_vld),  32'(e_vld));
      chk({tg, " rd_last"}, 32'(rd_last), 32'(j == len + 1 + RD_LAT));
      if (e_vld != 2'b00) begin
        ea = base + 8'(j - 1 - RD_LAT);
        chk({tg, " rd_data"}, rd_data, {24'hC0DE5A, ea});
      end
      chk({tg, " busy"}, 32'(busy), 32'(j <= len + 1 + RD_LAT));
    end
  endtask

  initial begin
    // rq, a0, a1, l0, l1, expected owner (ptr traced by hand from 0 after reset)
    tbl[0]  = '{2'b11, 8'h20, 8'h30, 4'd0, 4'd0, 0};   // both from reset: 0 first
    tbl[1]  = '{2'b11, 8'h20, 8'h30, 4'd0, 4'd0, 1};   // then 1, ptr back to 0
    tbl[2]  = '{2'b01, 8'h10, 8'h99, 4'd2, 4'd9, 0};   // basic 3-word burst
    tbl[3]  = '{2'b11, 8'h40, 8'h50, 4'd1, 4'd1, 1};   // held pair alternates
    tbl[4]  = '{2'b11, 8'h40, 8'h50, 4'd1, 4'd1, 0};
    tbl[5]  = '{2'b11, 8'h40, 8'h50, 4'd1, 4'd1, 1};
    tbl[6]  = '{2'b11, 8'h40, 8'h50, 4'd1, 4'd1, 0};
    tbl[7]  = '{2'b11, 8'h40, 8'h50, 4'd1, 4'd1, 1};
    tbl[8]  = '{2'b11, 8'h40, 8'h50, 4'd1, 4'd1, 0};
    tbl[9]  = '{2'b11, 8'h40, 8'h50, 4'd1, 4'd1, 1};
    tbl[10] = '{2'b11, 8'h40, 8'h50, 4'd1, 4'd1, 0};
    tbl[11] = '{2'b01, 8'hFE, 8'h00, 4'd3, 4'd0, 0};   // address wrap
    tbl[12] = '{2'b10, 8'h00, 8'h80, 4'd0, 4'd15, 1};  // max length
    tbl[13] = '{2'b11, 8'h05, 8'h06, 4'd0, 4'd0, 0};   // ptr=0 after owner 1
    tbl[14] = '{2'b01, 8'h07, 8'h08, 4'd0, 4'd0, 0};   // ptr=1 but only req[0]

    reset    = 1'b0;
    req      = '0;
    req_addr = '0;
    req_len  = '0;
    repeat (3) @(negedge clock);
    chk_idle_outputs("reset");
    chk("reset mem_addr", 32'(mem_addr), 32'h0);
    reset = 1'b1;

    repeat (3) begin
      @(negedge clock);
      chk_idle_outputs("idle");
    end

    for (int i = 0; i < 15; i++) run_burst(tbl[i], i);
    req = '0;

    // ptr is now 1. Start a 6-word burst on requester 0 and reset during word 2.
    req      = 2'b01;
    req_addr = {8'h00, 8'h60};
    req_len  = {4'd0, 4'd5};
    @(negedge clock);
    req = '0;
    @(negedge clock);
    @(negedge clock);
    chk("pre-reset mem_addr", 32'(mem_addr), 32'h62);
    #1 reset = 1'b0;
    #1;
    chk_idle_outputs("async reset");
    chk("async reset mem_addr", 32'(mem_addr), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clock);
      chk_idle_outputs($sformatf("post-reset c%0d", j));
    end

    // ptr must be back to 0 (requester 0 wins), then requester 1 alone with its own address.
    run_burst('{2'b11, 8'h11, 8'h22, 4'd0, 4'd0, 0}, 100);
    run_burst('{2'b10, 8'h00, 8'h77, 4'd0, 4'd0, 1}, 101);
    req = '0;
    @(negedge clock);
    chk_idle_outputs("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
